ps2_dev_tx: RTL and testbench

//  PS/2 device-side frame generator (keyboard emulator). Serialises one byte per

---
 rtl/ps2_dev_tx.sv | 132 +++++++++++++
 tb/tb_ps2_dev_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dev_tx.sv
// PS/2 device-side frame generator: one byte per handshake, device-timed ps2clk/ps2data.
// Optional build macro PS2_PARITY_INJ_EN adds a parity_flip input for parity error injection.
module ps2_dev_tx #(
  parameter int CLK_DIV    = 1000,
  parameter int GAP_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inhibit,
`ifdef PS2_PARITY_INJ_EN
  input  logic       parity_flip,
`endif
  output logic       ps2clk,
  output logic       ps2data,
  output logic       busy,
  output logic       tx_done
);

  // state  | meaning
  // S_IDLE | lines released, waiting for an accepted byte
  // S_HIGH | ps2clk high half of a bit slot, data presented
  // S_LOW  | ps2clk low half of a bit slot, receiver samples here
  // S_GAP  | lines released, mandatory idle time before next accept
  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [10:0]      shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             par_bit;
  logic             accept;
  logic             div_end;

`ifdef PS2_PARITY_INJ_EN
  assign par_bit = (~^tx_data) ^ parity_flip;
`else
  assign par_bit = ~^tx_data;
`endif

  assign tx_ready = (state_q == S_IDLE) & ~inhibit;
  assign accept   = tx_valid & tx_ready;
  assign busy     = (state_q != S_IDLE);
  assign div_end  = (div_cnt_q == DIV_LAST);

  // Lines are decoded straight from state so an async reset releases them at once.
  assign ps2clk  = (state_q != S_LOW);
  assign ps2data = ((state_q == S_HIGH) || (state_q == S_LOW)) ? shreg_q[0] : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '1;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    gap_cnt_d = gap_cnt_q;
    tx_done   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d   = {1'b1, par_bit, tx_data, 1'b0};
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          div_cnt_d = '0;
          state_d   = S_LOW;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_LOW: begin
        if (div_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 4'd10) begin
            tx_done   = 1'b1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            // Fill with ones so the line idles high once the stop bit has gone.
            shreg_d   = {1'b1, shreg_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = S_HIGH;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Scoreboard bench for ps2_dev_tx: stimulus pushes expected frames, a line-level
// receiver monitor decodes each frame and compares when tx_done pulses.
module tb_ps2_dev_tx;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       inhibit = 1'b0;
  logic       tx_ready, ps2clk, ps2data, busy, tx_done;
`ifdef PS2_PARITY_INJ_EN
  logic       parity_flip = 1'b0;
`endif

  ps2_dev_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .inhibit    (inhibit),
`ifdef PS2_PARITY_INJ_EN
    .parity_flip(parity_flip),
`endif
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] frame;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic par, input logic perr);
    exp_t e;
    e.frame = {1'b1, par, d, 1'b0};
    e.perr  = perr;
    exp_q.push_back(e);
  endtask

  // Returns the cycle in which the handshake was seen; leaves time just after the accept edge.
  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && !inhibit) begin
        acc = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("accept_timeout", 1'b0, 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready && !busy) return;
    end
    chk("idle_timeout", 1'b0, 0, 1);
  endtask

  // Receiver model: samples ps2data on every ps2clk falling edge.
  logic [10:0] rx_frame;
  int          rx_bits = 0;
  logic        prev_clk = 1'b1;
  logic        last_bit = 1'b1;
  logic        stab_bad = 1'b0;

  initial begin
    exp_t e;
    logic rx_perr;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rx_bits  = 0;
        prev_clk = 1'b1;
        stab_bad = 1'b0;
      end else begin
        if (prev_clk && !ps2clk) begin
          if (rx_bits < 11) rx_frame[rx_bits] = ps2data;
          last_bit = ps2data;
          rx_bits++;
        end else if (!ps2clk && (ps2data != last_bit)) begin
          stab_bad = 1'b1;
        end
        prev_clk = ps2clk;
        if (tx_done) begin
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 1'b0, int'(rx_frame), 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bits", (rx_bits == 11) && (rx_frame == e.frame) && !stab_bad,
                int'(rx_frame), int'(e.frame));
            rx_perr = ~(^rx_frame[9:1]);
            chk("rx_parity_err", rx_perr == e.perr, int'(rx_perr), int'(e.perr));
          end
          rx_bits  = 0;
          stab_bad = 1'b0;
        end
      end
    end
  end

  initial begin
    int acc, acc2, done_c, rdy_c, drop_c;
    logic p4, p5, ok;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_ps2clk", ps2clk == 1'b1, int'(ps2clk), 1);
    chk("idle_ps2data", ps2data == 1'b1, int'(ps2data), 1);
    chk("idle_tx_ready", tx_ready == 1'b1, int'(tx_ready), 1);
    chk("idle_busy", busy == 1'b0, int'(busy), 0);

    // 2: 0x1C, bits 0,0,0,1,1,1,0,0,0,0,1
    @(posedge clk); #1;
    tx_data = 8'h1C; tx_valid = 1'b1;
    push_exp(8'h1C, 1'b0, 1'b0);
    wait_accept(acc);
    tx_valid = 1'b0; tx_data = 8'hFF;
    done_c = -1; rdy_c = -1; p4 = 1'b0; p5 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc == acc + 1) chk("start_bit_busy", (ps2data == 1'b0) && busy, int'({busy, ps2data}), 2);
      if (cyc == acc + 4) p4 = ps2clk;
      if (cyc == acc + 5) p5 = ps2clk;
      if (tx_done && done_c < 0) done_c = cyc;
      if (tx_ready) begin
        rdy_c = cyc;
        break;
      end
    end
    chk("first_fall", (p4 == 1'b1) && (p5 == 1'b0), int'({p4, p5}), 2);
    chk("tx_done_time", done_c == acc + 88, done_c - acc, 88);
    chk("tx_ready_time", rdy_c == acc + 97, rdy_c - acc, 97);

    // 3: 0x00 then 0xFF with tx_valid held
    @(posedge clk); #1;
    tx_data = 8'h00; tx_valid = 1'b1;
    push_exp(8'h00, 1'b1, 1'b0);
    wait_accept(acc);
    tx_data = 8'hFF;
    push_exp(8'hFF, 1'b1, 1'b0);
    wait_accept(acc2);
    tx_valid = 1'b0;
    chk("b2b_accept_time", acc2 == acc + 97, acc2 - acc, 97);
    wait_idle();

    // 4: inhibit holds off a pending request
    @(posedge clk); #1;
    inhibit = 1'b1; tx_data = 8'h3A; tx_valid = 1'b1;
    push_exp(8'h3A, 1'b1, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(ps2clk && ps2data && !tx_ready && !busy)) ok = 1'b0;
    end
    chk("inhibit_hold", ok, int'(ok), 1);
    @(posedge clk); #1;
    inhibit = 1'b0;
    drop_c = cyc;
    wait_accept(acc);
    tx_valid = 1'b0;
    chk("inhibit_release_accept", acc == drop_c, acc - drop_c, 0);
    @(negedge clk);
    chk("inhibit_release_start", (ps2data == 1'b0) && busy, int'({busy, ps2data}), 2);
    wait_idle();

    // 5: reset in the low half of bit slot 5, then 0xA5
    @(posedge clk); #1;
    tx_data = 8'h00; tx_valid = 1'b1;
    push_exp(8'h00, 1'b1, 1'b0);
    wait_accept(acc);
    tx_valid = 1'b0;
    while (cyc < acc + 46) @(negedge clk);
    chk("pre_reset_lines", (ps2clk == 1'b0) && (ps2data == 1'b0), int'({ps2clk, ps2data}), 0);
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_lines_high", ps2clk && ps2data, int'({ps2clk, ps2data}), 3);
    chk("reset_ready_busy", tx_ready && !busy, int'({tx_ready, busy}), 2);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    push_exp(8'hA5, 1'b1, 1'b0);
    wait_accept(acc);
    tx_valid = 1'b0;
    wait_idle();

`ifdef PS2_PARITY_INJ_EN
    // 6: injected parity error on 0x1C
    @(posedge clk); #1;
    tx_data = 8'h1C; parity_flip = 1'b1; tx_valid = 1'b1;
    push_exp(8'h1C, 1'b1, 1'b1);
    wait_accept(acc);
    tx_valid = 1'b0; parity_flip = 1'b0;
    wait_idle();
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
